// File: rtl/seq_linear_layer.sv
// Time-multiplexed FC layer out = W*x + b on NUM_MAC MAC lanes; SEQ_LINEAR_LAYER_FUSED_RELU_EN clamps negative results to 0.
// Latency K=(OUT_SIZE/NUM_MAC)*IN_SIZE cycles; result held in DONE until out_ready, no input accepted outside IDLE.
module seq_linear_layer #(
    parameter int IN_SIZE  = 4,
    parameter int OUT_SIZE = 64,
    parameter int DATA_W   = 32,
    parameter int FRAC_W   = 16,
    parameter int NUM_MAC  = 4,
    parameter int ACC_W    = 2*DATA_W+8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [IN_SIZE*DATA_W-1:0]           in_data,
    input  logic [OUT_SIZE*IN_SIZE*DATA_W-1:0]  weights,
    input  logic [OUT_SIZE*DATA_W-1:0]          biases,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [OUT_SIZE*DATA_W-1:0]          out_data,
    output logic                                busy
);
    localparam int NUM_GRP = OUT_SIZE / NUM_MAC;
    localparam int G_W     = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
    localparam int J_W     = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam logic [G_W-1:0] G_LAST = G_W'(NUM_GRP - 1);
    localparam logic [J_W-1:0] J_LAST = J_W'(IN_SIZE - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t                     state_q, state_d;
    logic [G_W-1:0]             g_q, g_d;
    logic [J_W-1:0]             j_q, j_d;
    logic [IN_SIZE*DATA_W-1:0]  x_q, x_d;
    logic [OUT_SIZE*DATA_W-1:0] out_data_q, out_data_d;
    logic signed [ACC_W-1:0]    acc_q   [NUM_MAC];
    logic signed [ACC_W-1:0]    acc_d   [NUM_MAC];
    logic signed [ACC_W-1:0]    acc_nxt [NUM_MAC];
    logic [DATA_W-1:0]          res     [NUM_MAC];

    // All lanes consume the same input element in a given cycle.
    logic signed [DATA_W-1:0] x_sel;
    assign x_sel = x_q[(IN_SIZE-1-int'(j_q))*DATA_W +: DATA_W];

    for (genvar l = 0; l < NUM_MAC; l++) begin : g_lane
        int                        o_idx;
        logic signed [DATA_W-1:0]  w_sel;
        logic signed [DATA_W-1:0]  b_sel;
        logic signed [2*DATA_W-1:0] prod;
        logic signed [ACC_W-1:0]   base;
        logic signed [ACC_W-1:0]   shifted;
        logic [DATA_W-1:0]         sat;

        assign o_idx = int'(g_q) * NUM_MAC + l;
        assign w_sel = weights[(OUT_SIZE*IN_SIZE-1-(o_idx*IN_SIZE+int'(j_q)))*DATA_W +: DATA_W];
        assign b_sel = biases[(OUT_SIZE-1-o_idx)*DATA_W +: DATA_W];
        assign prod  = x_sel * w_sel;

        // Bias is pre-aligned to the product's 2*FRAC_W binary point when a row starts.
        assign base = (j_q == '0) ? ({{(ACC_W-DATA_W){b_sel[DATA_W-1]}}, b_sel} << FRAC_W) : acc_q[l];
        assign acc_nxt[l] = base + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        assign shifted    = acc_nxt[l] >>> FRAC_W;

        always_comb begin
            if (shifted > SAT_MAX) begin
                sat = SAT_MAX[DATA_W-1:0];
            end else if (shifted < SAT_MIN) begin
                sat = SAT_MIN[DATA_W-1:0];
            end else begin
                sat = shifted[DATA_W-1:0];
            end
        end

`ifdef SEQ_LINEAR_LAYER_FUSED_RELU_EN
        assign res[l] = sat[DATA_W-1] ? '0 : sat;
`else
        assign res[l] = sat;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            g_q        <= '0;
            j_q        <= '0;
            x_q        <= '0;
            out_data_q <= '0;
            for (int l = 0; l < NUM_MAC; l++) begin
                acc_q[l] <= '0;
            end
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            j_q        <= j_d;
            x_q        <= x_d;
            out_data_q <= out_data_d;
            for (int l = 0; l < NUM_MAC; l++) begin
                acc_q[l] <= acc_d[l];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        j_d        = j_q;
        x_d        = x_q;
        out_data_d = out_data_q;
        acc_d      = acc_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    x_d     = in_data;
                    g_d     = '0;
                    j_d     = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                busy  = 1'b1;
                acc_d = acc_nxt;
                if (j_q == J_LAST) begin
                    j_d = '0;
                    for (int l = 0; l < NUM_MAC; l++) begin
                        out_data_d[(OUT_SIZE-1-(int'(g_q)*NUM_MAC+l))*DATA_W +: DATA_W] = res[l];
                    end
                    if (g_q == G_LAST) begin
                        g_d     = '0;
                        state_d = DONE;
                    end else begin
                        g_d = g_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_data = out_data_q;

endmodule

// File: doc/seq_linear_layer.md
Name: seq_linear_layer

Overview:
Time-multiplexed fully-connected layer for the SoH predictor network. It computes out = W*x + b with NUM_MAC parallel multiply-accumulate lanes instead of a fully unrolled array. The layer uses valid/ready handshakes on both sides, so layers can be chained with backpressure. Fixed-point precision is parametrised, the accumulator is full-precision and the output saturates.

Parameters:
IN_SIZE, 4, input vector length
OUT_SIZE, 64, output vector length
DATA_W, 32, signed fixed-point word width for inputs, weights, biases and outputs
FRAC_W, 16, fractional bits (default Q16.16)
NUM_MAC, 4, parallel MAC lanes; must divide OUT_SIZE
ACC_W, 2*DATA_W+8, accumulator width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input vector valid
in_ready  out  1  block can accept a vector
in_data  in  IN_SIZE*DATA_W  input vector; element i at [(IN_SIZE-1-i)*DATA_W +: DATA_W]
weights  in  OUT_SIZE*IN_SIZE*DATA_W  row-major W[o][j] at [(OUT_SIZE*IN_SIZE-1-(o*IN_SIZE+j))*DATA_W +: DATA_W]
biases  in  OUT_SIZE*DATA_W  bias o at [(OUT_SIZE-1-o)*DATA_W +: DATA_W]
out_valid  out  1  out_data holds a complete result
out_ready  in  1  downstream accepts the result
out_data  out  OUT_SIZE*DATA_W  result vector, same packing as biases
busy  out  1  high in COMPUTE

Behaviour:
- Reset (asynchronous, active-high; clock clk): state IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, accumulators and counters cleared. Asserting reset mid-COMPUTE or in DONE aborts the operation; the partial result is never presented.
- Timing: K = (OUT_SIZE/NUM_MAC)*IN_SIZE.
- IDLE: in_ready=1. When in_valid&&in_ready at an edge, in_data is captured into an internal register and the state moves to COMPUTE with group g=0 and index j=0.
- COMPUTE: in_ready=0, busy=1. Each cycle, lane l (o=g*NUM_MAC+l) does:
  - acc[l] = (j==0 ? sext(b[o])<<FRAC_W : acc[l]) + x[j]*W[o][j], using a full 2*DATA_W signed product with no per-product truncation.
  - When j reaches IN_SIZE-1, each lane's result is written into out_data slot o, j wraps to 0 and g increments.
- Result conversion: acc >>> FRAC_W (arithmetic shift), then saturate to the signed DATA_W range [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Completion: on the edge that writes the last group, the state moves to DONE and out_valid=1. out_valid rises K cycles after the input handshake edge.
- Weight/bias stability: weights and biases are sampled live during COMPUTE and must be held stable by the producer. in_data may change freely after its handshake.
- DONE: out_valid=1. out_data is held stable until out_valid&&out_ready. On that edge, out_valid drops and the state returns to IDLE.
- Throughput: in_ready returns high the cycle after the output handshake. Inputs are not accepted in DONE (no overlap). Maximum throughput is one vector per K+2 cycles.
- Stray inputs: in_valid asserted outside IDLE is ignored and nothing is captured.
- out_ready with out_valid low has no effect.

Optional Feature:
Macro SEQ_LINEAR_LAYER_FUSED_RELU_EN.
- Defined: each saturated result is clamped to 0 if negative before being written to out_data, so no separate ReLU stage is needed.
- Undefined: the signed saturated result is output unchanged.

Test Plan:
- Basic case. Params IN=2, OUT=2, NUM_MAC=1. Stimulus: x=[0x00010000, 0x00020000], W=[[0x00008000, 0x00004000], [0xFFFF0000, 0x00010000]], b=[0x00002000, 0]. Response: out=[0x00012000, 0x00010000], with out_valid rising exactly 4 cycles after the input handshake.
- Saturation. Stimulus: x=[0x7FFF0000, 0x7FFF0000], W row0=[0x00010000, 0x00010000], row1=[0xFFFF0000, 0xFFFF0000], b=0. Response: out=[0x7FFFFFFF, 0x80000000]. With the macro defined, out1=0.
- Backpressure. Stimulus: hold out_ready=0 for 6 cycles in DONE, and assert a second in_valid during that time. Response: out_data is stable, in_ready=0, and the second vector is not captured. It is accepted only after the output handshake.
- Lanes. Same data as the basic case with NUM_MAC=2. Response: identical out values, with out_valid 2 cycles after the handshake.
- Mid-compute reset. Stimulus: assert reset 1 cycle after the input handshake, then run a new vector. Response: out_valid=0 and out_data=0 immediately; the new vector gives the correct result with no residue from the aborted run.
- Back-to-back. Stimulus: stream 3 vectors with in_valid and out_ready held high. Response: each result matches the reference model, and in_ready pulses once per K+2 cycles.
